// File: rtl/gene_net_pkg.sv
// Shared types and default sizing for the gene regulatory network sequencer.
package gene_net_pkg;

  // Default number of genes (state bits).
  localparam int unsigned NDefault = 8;
  // Default width of the step limit and step counter.
  localparam int unsigned SwDefault = 16;

  // Run-control FSM states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/gene_net_rule.sv
// Next-state function of a single gene: activation term gated by the inhibitor term.
module gene_net_rule #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] x_i,
  input  logic [N-1:0] act_i,
  input  logic [N-1:0] inh_i,
  input  logic         and_mode_i,
  output logic         x_next_o
);

  logic act_term;
  logic inh_hit;

  // AND mode needs every masked activator set (empty mask -> 1); OR mode needs any (empty -> 0).
  always_comb begin
    act_term = and_mode_i ? &(x_i | ~act_i) : |(x_i & act_i);
    inh_hit  = |(x_i & inh_i);
    x_next_o = act_term & ~inh_hit;
  end

endmodule

// File: rtl/gene_net_seq.sv
// Synchronous Boolean gene network: programmable rule table, bounded run with
// fixed-point detection, abort and per-step output strobe.
module gene_net_seq
  import gene_net_pkg::*;
#(
  parameter int unsigned N  = NDefault,
  parameter int unsigned SW = SwDefault,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [N-1:0]  cfg_act,
  input  logic [N-1:0]  cfg_inh,
  input  logic          cfg_and,
  input  logic          init_valid,
  input  logic [N-1:0]  init_val,
  input  logic          start,
  input  logic [SW-1:0] max_steps,
  input  logic          stop,
  output logic [N-1:0]  x_out,
  output logic          step_valid,
  output logic [SW-1:0] step_cnt,
  output logic          busy,
  output logic          done,
  output logic          fixed_pt
);

  // Rule table.
  logic [N-1:0] act_q [N];
  logic [N-1:0] inh_q [N];
  logic [N-1:0] and_q;
  logic         tbl_we;

  // Run state.
  state_e        state_q, state_d;
  logic [N-1:0]  x_q, x_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] limit_q, limit_d;
  logic          fixed_q, fixed_d;
  logic          step_valid_q, step_valid_d;
  logic          busy_q, done_q;

  logic [N-1:0]  x_next;
  logic [SW-1:0] cnt_inc;

  for (genvar g = 0; g < N; g++) begin : g_rule
    gene_net_rule #(
      .N (N)
    ) u_rule (
      .x_i        (x_q),
      .act_i      (act_q[g]),
      .inh_i      (inh_q[g]),
      .and_mode_i (and_q[g]),
      .x_next_o   (x_next[g])
    );
  end

  assign cnt_inc = cnt_q + SW'(1);

  // FSM next state and datapath updates; defaults hold everything.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    cnt_d        = cnt_q;
    limit_d      = limit_q;
    fixed_d      = fixed_q;
    step_valid_d = 1'b0;
    tbl_we       = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        tbl_we = cfg_we && (32'(cfg_idx) < N);
        if (init_valid) begin
          // Init wins over a simultaneous start.
          x_d     = init_val;
          cnt_d   = '0;
          fixed_d = 1'b0;
          state_d = StIdle;
        end else if (start) begin
          limit_d = max_steps;
          cnt_d   = '0;
          fixed_d = 1'b0;
          state_d = (max_steps == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (stop) begin
          // Abort without updating; state and count are held.
          fixed_d = 1'b0;
          state_d = StIdle;
        end else begin
          x_d          = x_next;
          cnt_d        = cnt_inc;
          step_valid_d = 1'b1;
          if (x_next == x_q) begin
            fixed_d = 1'b1;
            state_d = StDone;
          end else if (cnt_inc == limit_q) begin
            fixed_d = 1'b0;
            state_d = StDone;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Run-state registers, including registered busy/done decodes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      x_q          <= '0;
      cnt_q        <= '0;
      limit_q      <= '0;
      fixed_q      <= 1'b0;
      step_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      cnt_q        <= cnt_d;
      limit_q      <= limit_d;
      fixed_q      <= fixed_d;
      step_valid_q <= step_valid_d;
      busy_q       <= (state_d == StRun);
      done_q       <= (state_d == StDone);
    end
  end

  // Rule table storage; cleared by reset, written one gene at a time.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N); i++) begin
        act_q[i] <= '0;
        inh_q[i] <= '0;
      end
      and_q <= '0;
    end else if (tbl_we) begin
      act_q[cfg_idx] <= cfg_act;
      inh_q[cfg_idx] <= cfg_inh;
      and_q[cfg_idx] <= cfg_and;
    end
  end

  assign x_out      = x_q;
  assign step_valid = step_valid_q;
  assign step_cnt   = cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fixed_pt   = fixed_q;

endmodule

// File: doc/gene_net_seq.md
GENE_NET_SEQ -- requirements
Module: gene_net_seq

Interface
REQ-001 Parameter N, default 8: number of genes (state bits); legal range 2..32.
REQ-002 Parameter SW, default 16: width of step limit and step counter.
REQ-003 Derived constant IW = clog2(N): gene index width.
REQ-004 One clock; reset is synchronous and active-high: ports clk and rst.
REQ-005 clk  in  1  clock; all state changes on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 cfg_we  in  1  write one rule-table entry this cycle.
REQ-008 cfg_idx  in  IW  gene index of the rule entry being written.
REQ-009 cfg_act  in  N  activator mask for gene cfg_idx.
REQ-010 cfg_inh  in  N  inhibitor mask for gene cfg_idx.
REQ-011 cfg_and  in  1  activator combine mode: 1 = AND, 0 = OR.
REQ-012 init_valid  in  1  load init_val into the network state.
REQ-013 init_val  in  N  initial state x[0].
REQ-014 start  in  1  begin a run of up to max_steps updates.
REQ-015 max_steps  in  SW  step limit, sampled when start is accepted.
REQ-016 stop  in  1  abort a run in progress.
REQ-017 x_out  out  N  current network state x[t].
REQ-018 step_valid  out  1  one-cycle pulse: x_out holds a newly computed state.
REQ-019 step_cnt  out  SW  number of updates performed in the current run.
REQ-020 busy  out  1  high while in RUN.
REQ-021 done  out  1  high while in DONE.
REQ-022 fixed_pt  out  1  valid while done; 1 = run ended because the state did not change.

Function
REQ-023 Rule table SHALL hold, per gene i: act[i], inh[i] (N bits each) and and_mode[i].
REQ-024 Activation term: OR mode = |(x & act[i]); AND mode = &(x | ~act[i]); act[i]=0 gives 0 in OR mode and 1 in AND mode.
REQ-025 Next state: x_next[i] = activation term & ~|(x & inh[i]), computed combinationally from x_out.
REQ-026 FSM states IDLE, RUN, DONE; reset enters IDLE.
REQ-027 IDLE/DONE: cfg_we writes the entry at cfg_idx; cfg_idx >= N is ignored.
REQ-028 IDLE/DONE: init_valid loads x_out <= init_val, clears step_cnt and fixed_pt, next state IDLE.
REQ-029 IDLE/DONE: start without init_valid latches max_steps and clears step_cnt; max_steps = 0 goes to DONE with fixed_pt = 0; otherwise goes to RUN.
REQ-030 init_valid and start in the same cycle: init wins and start is dropped.
REQ-031 RUN edge: x_out <= x_next, step_cnt += 1, step_valid = 1 in the following cycle, so it is aligned with the new x_out.
REQ-032 RUN exit: if x_next == x_out or step_cnt+1 == limit, go to DONE on that same edge; fixed_pt <= (x_next == x_out), and the fixed-point result has priority when both conditions hold.
REQ-033 done rises in the same cycle as the final step_valid; step_cnt never exceeds the limit and never wraps.
REQ-034 RUN: cfg_we, init_valid and start are ignored.
REQ-035 stop in RUN: no update on that edge; go to IDLE; x_out and step_cnt are held; fixed_pt = 0; stop has priority over the exit conditions.
REQ-036 stop outside RUN is ignored.
REQ-037 busy = (state == RUN); done = (state == DONE); both are registered.

Reset
REQ-038 rst SHALL give: state IDLE, x_out = 0, step_cnt = 0, step_valid = 0, fixed_pt = 0, latched limit = 0.
REQ-039 rst SHALL clear every rule entry: act, inh and and_mode all zero.
REQ-040 rst SHALL take priority over every other input, including in the middle of a run.

Structure
REQ-041 A shared package gene_net_pkg SHALL hold the FSM state enum and the default N/SW constants.
REQ-042 One sub-module, gene_net_rule (a single gene's next-state function), SHALL be instantiated N times with a generate loop.

Verification (N=8; table: g0 40/84, g1 30/80, g2 80/00, g3 02/40, g4 0A/00, g5 04/80, g6 02/80, g7 48/03, format act/inh hex, all OR mode)
REQ-043 Load the table, init 0x02, start with max_steps 2 -> step_valid with x_out = 0x58, then x_out = 0x93 with done = 1, fixed_pt = 0, step_cnt = 2.
REQ-044 Init 0x00, start with max_steps 10 -> one step, x_out = 0x00, done = 1, fixed_pt = 1, step_cnt = 1.
REQ-045 Init 0x02, start with max_steps 100, stop asserted after 3 steps -> IDLE, step_cnt = 3, x_out unchanged by the stop cycle.
REQ-046 start with max_steps 0 -> DONE next cycle, step_cnt = 0, fixed_pt = 0, no step_valid.
REQ-047 cfg_we, init_valid and start pulsed during RUN -> ignored; after DONE, readback of the state trajectory matches the original table.
REQ-048 rst asserted during RUN -> next cycle IDLE, all outputs 0; with the table cleared, init 0xFF plus one step gives 0x00.
